// File: rtl/rvsteel_debouncer.sv
// ---------------------------------------------------------------------------
// rvsteel_debouncer
//
// Multi-channel input conditioner for board top levels. Each raw pin goes
// through a two-flop synchroniser and a counter-based stability filter. The
// filter is clocked by a shared sample tick from a prescaler. An input must
// disagree with the debounced output for STABLE_TICKS consecutive ticks
// before the output follows it. Any single cycle of agreement restarts the
// count.
//
// Optional feature macro: RVSTEEL_DEBOUNCER_EDGE_EN
//   defined   : rise/fall are registered one-cycle edge pulses that coincide
//               with the first cycle dout shows its new value.
//   undefined : rise/fall are tied to 0 and no edge registers exist.
//
// Parameters:
//   CHANNELS     number of independent channels (>=1)
//   TICK_CYCLES  clock cycles per sample tick (>=1)
//   STABLE_TICKS consecutive disagreeing ticks needed to commit (>=1)
//   RESET_VALUE  reset value of synchronisers and dout
//
// Ports:
//   clock  in   single clock, rising edge
//   reset  in   synchronous, active-high
//   din    in   [CHANNELS] raw asynchronous pin levels
//   dout   out  [CHANNELS] debounced levels (registered)
//   rise   out  [CHANNELS] one-cycle pulse on dout 0->1
//   fall   out  [CHANNELS] one-cycle pulse on dout 1->0
//
// Per-channel state is implicit: IDLE when sync2 == dout, PENDING otherwise.
// The internal vector `pending` exposes that state for checkers.
// ---------------------------------------------------------------------------
module rvsteel_debouncer #(
  parameter int                  CHANNELS     = 3,
  parameter int                  TICK_CYCLES  = 50000,
  parameter int                  STABLE_TICKS = 10,
  parameter logic [CHANNELS-1:0] RESET_VALUE  = {CHANNELS{1'b0}}
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] dout,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int STAB_W = $clog2(STABLE_TICKS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_TICKS - 1);

  // -------------------------------------------------------------------------
  // Two-flop synchroniser
  // -------------------------------------------------------------------------
  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= RESET_VALUE;
      sync2 <= RESET_VALUE;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // -------------------------------------------------------------------------
  // Shared prescaler. With TICK_CYCLES == 1 the count sits at 0, which equals
  // TICK_LAST, so tick is permanently high.
  // -------------------------------------------------------------------------
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Per-channel stability filter
  // -------------------------------------------------------------------------
  logic [CHANNELS-1:0] pending;   // per-channel state: 1 = PENDING, 0 = IDLE
  logic [CHANNELS-1:0] commit;    // dout takes sync2 on this edge
  logic [CHANNELS-1:0] dout_nxt;
  logic [STAB_W-1:0]   stab_cnt [CHANNELS];
  logic [STAB_W-1:0]   stab_nxt [CHANNELS];

  assign pending = sync2 ^ dout;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      dout <= RESET_VALUE;
      for (int i = 0; i < CHANNELS; i++) begin
        stab_cnt[i] <= '0;
      end
    end else begin
      dout <= dout_nxt;
      for (int i = 0; i < CHANNELS; i++) begin
        stab_cnt[i] <= stab_nxt[i];
      end
    end
  end

  // Next-state logic. Agreement clears the counter even on a tick, so a
  // single-cycle bounce back to the dout level restarts the full count.
  // The counter never goes past STAB_LAST, so it cannot wrap.
  always_comb begin
    commit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      stab_nxt[i] = stab_cnt[i];
      if (!pending[i]) begin
        stab_nxt[i] = '0;
      end else if (tick) begin
        if (stab_cnt[i] == STAB_LAST) begin
          commit[i]   = 1'b1;
          stab_nxt[i] = '0;
        end else begin
          stab_nxt[i] = stab_cnt[i] + STAB_W'(1);
        end
      end
    end
    dout_nxt = (dout & ~commit) | (sync2 & commit);
  end

  // -------------------------------------------------------------------------
  // Edge pulses. They are registered on the commit edge, so they line up
  // with the first cycle dout shows the new level. Reset forces sync2 and
  // dout to the same value, so no commit (and no pulse) can follow reset.
  // -------------------------------------------------------------------------
`ifdef RVSTEEL_DEBOUNCER_EDGE_EN
  logic [CHANNELS-1:0] rise_nxt;
  logic [CHANNELS-1:0] fall_nxt;

  // Output logic
  always_comb begin
    rise_nxt = commit & sync2;
    fall_nxt = commit & ~sync2;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rise <= '0;
      fall <= '0;
    end else begin
      rise <= rise_nxt;
      fall <= fall_nxt;
    end
  end
`else
  assign rise = '0;
  assign fall = '0;
`endif

endmodule

// File: tb/tb_rvsteel_debouncer.sv
// ---------------------------------------------------------------------------
// Testbench for rvsteel_debouncer with CHANNELS=3, TICK_CYCLES=4 and
// STABLE_TICKS=3. dut uses RESET_VALUE=3'b000 and dut_b uses 3'b111.
// Edge-pulse expectations follow RVSTEEL_DEBOUNCER_EDGE_EN: with the macro
// defined, pulses are expected; without it, rise/fall must stay 0.
// A clean step reaches dout 11..14 edges after the input change.
// ---------------------------------------------------------------------------
module tb_rvsteel_debouncer;

  localparam int CH = 3;
  localparam int TC = 4;
  localparam int ST = 3;
  localparam int LAT_MIN = (ST - 1) * TC + 3;  // 11
  localparam int LAT_MAX = ST * TC + 2;        // 14
  localparam int WAIT_MAX = 40;

`ifdef RVSTEEL_DEBOUNCER_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  // ---------------------------------------------------------------- clock/reset
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset;
  logic          reset_b;
  logic [CH-1:0] din;
  logic [CH-1:0] din_b;
  logic [CH-1:0] dout;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic [CH-1:0] dout_b;
  logic [CH-1:0] rise_b;
  logic [CH-1:0] fall_b;

  int checks   = 0;
  int failures = 0;

  rvsteel_debouncer #(
    .CHANNELS(CH), .TICK_CYCLES(TC), .STABLE_TICKS(ST), .RESET_VALUE(3'b000)
  ) dut (
    .clock(clock), .reset(reset), .din(din),
    .dout(dout), .rise(rise), .fall(fall)
  );

  rvsteel_debouncer #(
    .CHANNELS(CH), .TICK_CYCLES(TC), .STABLE_TICKS(ST), .RESET_VALUE(3'b111)
  ) dut_b (
    .clock(clock), .reset(reset_b), .din(din_b),
    .dout(dout_b), .rise(rise_b), .fall(fall_b)
  );

  // ------------------------------------------------------------------ driver
  // Advance one clock; inputs are driven and outputs sampled 1 ns after it.
  task automatic step_cycle();
    @(posedge clock);
    #1;
  endtask

  // ------------------------------------------------------------------- tests
  task automatic test_reset();
    reset = 1'b1;
    din   = 3'b000;
    repeat (3) step_cycle();
    checks++;
    if (dout !== 3'b000) begin
      failures++; $display("FAIL reset_dout actual=%b expected=%b", dout, 3'b000);
    end
    checks++;
    if (rise !== 3'b000) begin
      failures++; $display("FAIL reset_rise actual=%b expected=%b", rise, 3'b000);
    end
    checks++;
    if (fall !== 3'b000) begin
      failures++; $display("FAIL reset_fall actual=%b expected=%b", fall, 3'b000);
    end
  endtask

  task automatic test_clean_step();
    int k;
    int bad;
    int fall_hits;
    bit seen;
    logic [CH-1:0] exp_rise;
    exp_rise = EDGE_EN ? 3'b001 : 3'b000;
    reset = 1'b0;
    bad = 0;
    repeat (3) begin
      step_cycle();
      if (dout !== 3'b000 || rise !== 3'b000 || fall !== 3'b000) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL post_reset_quiet actual=%0d expected=0", bad);
    end
    din[0] = 1'b1;
    k = 0; seen = 1'b0; fall_hits = 0;
    while (!seen && k < WAIT_MAX) begin
      step_cycle();
      k++;
      if (fall !== 3'b000) fall_hits++;
      if (dout[0] === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++; $display("FAIL clean_timeout actual=%0d expected=%0d..%0d", k, LAT_MIN, LAT_MAX);
    end
    checks++;
    if (k < LAT_MIN || k > LAT_MAX) begin
      failures++; $display("FAIL clean_latency actual=%0d expected=%0d..%0d", k, LAT_MIN, LAT_MAX);
    end
    checks++;
    if (dout !== 3'b001) begin
      failures++; $display("FAIL clean_dout actual=%b expected=%b", dout, 3'b001);
    end
    checks++;
    if (rise !== exp_rise) begin
      failures++; $display("FAIL clean_rise actual=%b expected=%b", rise, exp_rise);
    end
    step_cycle();
    if (fall !== 3'b000) fall_hits++;
    checks++;
    if (rise !== 3'b000) begin
      failures++; $display("FAIL clean_rise_width actual=%b expected=%b", rise, 3'b000);
    end
    checks++;
    if (dout !== 3'b001) begin
      failures++; $display("FAIL clean_dout_hold actual=%b expected=%b", dout, 3'b001);
    end
    checks++;
    if (fall_hits != 0) begin
      failures++; $display("FAIL clean_no_fall actual=%0d expected=0", fall_hits);
    end
  endtask

  task automatic test_bounce();
    int k;
    int dout1_hi;
    int pulse_hits;
    bit seen;
    logic [CH-1:0] exp_rise;
    exp_rise = EDGE_EN ? 3'b010 : 3'b000;
    dout1_hi = 0; pulse_hits = 0;
    for (int t = 0; t < 12; t++) begin
      din[1] = ~din[1];
      repeat (5) begin
        step_cycle();
        if (dout !== 3'b001) dout1_hi++;
        if (rise !== 3'b000 || fall !== 3'b000) pulse_hits++;
      end
    end
    checks++;
    if (dout1_hi != 0) begin
      failures++; $display("FAIL bounce_dout_stable actual=%0d expected=0", dout1_hi);
    end
    checks++;
    if (pulse_hits != 0) begin
      failures++; $display("FAIL bounce_no_pulse actual=%0d expected=0", pulse_hits);
    end
    din[1] = 1'b1;
    k = 0; seen = 1'b0;
    while (!seen && k < WAIT_MAX) begin
      step_cycle();
      k++;
      if (dout[1] === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || k < LAT_MIN || k > LAT_MAX) begin
      failures++; $display("FAIL bounce_latency actual=%0d expected=%0d..%0d", k, LAT_MIN, LAT_MAX);
    end
    checks++;
    if (dout !== 3'b011) begin
      failures++; $display("FAIL bounce_dout actual=%b expected=%b", dout, 3'b011);
    end
    checks++;
    if (rise !== exp_rise) begin
      failures++; $display("FAIL bounce_rise actual=%b expected=%b", rise, exp_rise);
    end
    step_cycle();
    checks++;
    if (rise !== 3'b000) begin
      failures++; $display("FAIL bounce_rise_width actual=%b expected=%b", rise, 3'b000);
    end
  endtask

  task automatic test_simultaneous();
    int k;
    bit seen;
    logic [CH-1:0] exp_pulse;
    exp_pulse = EDGE_EN ? 3'b101 : 3'b000;
    reset = 1'b1;
    din   = 3'b000;
    repeat (2) step_cycle();
    reset = 1'b0;
    step_cycle();
    din = 3'b101;
    k = 0; seen = 1'b0;
    while (!seen && k < WAIT_MAX) begin
      step_cycle();
      k++;
      if (dout !== 3'b000) seen = 1'b1;
    end
    checks++;
    if (!seen || k < LAT_MIN || k > LAT_MAX) begin
      failures++; $display("FAIL simul_rise_latency actual=%0d expected=%0d..%0d", k, LAT_MIN, LAT_MAX);
    end
    checks++;
    if (dout !== 3'b101) begin
      failures++; $display("FAIL simul_dout_rise actual=%b expected=%b", dout, 3'b101);
    end
    checks++;
    if (rise !== exp_pulse) begin
      failures++; $display("FAIL simul_rise actual=%b expected=%b", rise, exp_pulse);
    end
    step_cycle();
    checks++;
    if (rise !== 3'b000) begin
      failures++; $display("FAIL simul_rise_width actual=%b expected=%b", rise, 3'b000);
    end
    din = 3'b000;
    k = 0; seen = 1'b0;
    while (!seen && k < WAIT_MAX) begin
      step_cycle();
      k++;
      if (dout !== 3'b101) seen = 1'b1;
    end
    checks++;
    if (!seen || k < LAT_MIN || k > LAT_MAX) begin
      failures++; $display("FAIL simul_fall_latency actual=%0d expected=%0d..%0d", k, LAT_MIN, LAT_MAX);
    end
    checks++;
    if (dout !== 3'b000) begin
      failures++; $display("FAIL simul_dout_fall actual=%b expected=%b", dout, 3'b000);
    end
    checks++;
    if (fall !== exp_pulse || rise !== 3'b000) begin
      failures++; $display("FAIL simul_fall actual=%b/%b expected=%b/%b", fall, rise, exp_pulse, 3'b000);
    end
  endtask

  task automatic test_reset_mid_count();
    int k;
    int early_pulse;
    bit seen;
    logic [CH-1:0] exp_rise;
    exp_rise = EDGE_EN ? 3'b001 : 3'b000;
    din[0] = 1'b1;
    repeat (8) step_cycle();
    checks++;
    if (dout !== 3'b000) begin
      failures++; $display("FAIL midreset_no_early actual=%b expected=%b", dout, 3'b000);
    end
    reset = 1'b1;
    step_cycle();
    reset = 1'b0;
    checks++;
    if (dout !== 3'b000 || rise !== 3'b000) begin
      failures++; $display("FAIL midreset_during actual=%b/%b expected=%b/%b", dout, rise, 3'b000, 3'b000);
    end
    // Prescaler restarts at reset, so the commit edge is fixed: ticks land on
    // edges 4, 8 and 12 after the reset edge.
    k = 0; seen = 1'b0; early_pulse = 0;
    while (!seen && k < WAIT_MAX) begin
      step_cycle();
      k++;
      if (dout[0] === 1'b1) seen = 1'b1;
      else if (rise !== 3'b000 || fall !== 3'b000) early_pulse++;
    end
    checks++;
    if (early_pulse != 0) begin
      failures++; $display("FAIL midreset_no_pulse actual=%0d expected=0", early_pulse);
    end
    checks++;
    if (!seen || k != 12) begin
      failures++; $display("FAIL midreset_latency actual=%0d expected=12", k);
    end
    checks++;
    if (rise !== exp_rise) begin
      failures++; $display("FAIL midreset_rise actual=%b expected=%b", rise, exp_rise);
    end
  endtask

  task automatic test_falling_reset_value();
    int k;
    int bad;
    int fall_total;
    int rise_total;
    bit seen;
    logic [CH-1:0] exp_fall;
    exp_fall = EDGE_EN ? 3'b100 : 3'b000;
    reset_b = 1'b1;
    din_b   = 3'b111;
    repeat (3) step_cycle();
    checks++;
    if (dout_b !== 3'b111 || rise_b !== 3'b000 || fall_b !== 3'b000) begin
      failures++; $display("FAIL rv_reset actual=%b/%b/%b expected=111/000/000", dout_b, rise_b, fall_b);
    end
    reset_b = 1'b0;
    bad = 0;
    repeat (20) begin
      step_cycle();
      if (dout_b !== 3'b111 || rise_b !== 3'b000 || fall_b !== 3'b000) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL rv_quiet actual=%0d expected=0", bad);
    end
    din_b[2] = 1'b0;
    k = 0; seen = 1'b0; fall_total = 0; rise_total = 0;
    while (!seen && k < WAIT_MAX) begin
      step_cycle();
      k++;
      if (fall_b[2] === 1'b1) fall_total++;
      if (rise_b !== 3'b000) rise_total++;
      if (dout_b[2] === 1'b0) seen = 1'b1;
    end
    checks++;
    if (!seen || k < LAT_MIN || k > LAT_MAX) begin
      failures++; $display("FAIL rv_latency actual=%0d expected=%0d..%0d", k, LAT_MIN, LAT_MAX);
    end
    checks++;
    if (dout_b !== 3'b011) begin
      failures++; $display("FAIL rv_dout actual=%b expected=%b", dout_b, 3'b011);
    end
    checks++;
    if (fall_b !== exp_fall) begin
      failures++; $display("FAIL rv_fall actual=%b expected=%b", fall_b, exp_fall);
    end
    repeat (5) begin
      step_cycle();
      if (fall_b[2] === 1'b1) fall_total++;
      if (rise_b !== 3'b000) rise_total++;
    end
    checks++;
    if (fall_total != (EDGE_EN ? 1 : 0)) begin
      failures++; $display("FAIL rv_fall_count actual=%0d expected=%0d", fall_total, EDGE_EN ? 1 : 0);
    end
    checks++;
    if (rise_total != 0) begin
      failures++; $display("FAIL rv_no_rise actual=%0d expected=0", rise_total);
    end
  endtask

  // ------------------------------------------------------------------ report
  initial begin
    reset   = 1'b1;
    reset_b = 1'b1;
    din     = 3'b000;
    din_b   = 3'b111;
    test_reset();
    test_clean_step();
    test_bounce();
    test_simultaneous();
    test_reset_mid_count();
    test_falling_reset_value();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
